// File: rtl/hyperbus_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hyperbus_pkg: shared types and default timing constants for the CS guard.
// Rev 1.0
// ----------------------------------------------------------------------------
package hyperbus_pkg;

  typedef enum logic [1:0] {
    READY   = 2'd0,
    ACTIVE  = 2'd1,
    RECOVER = 2'd2
  } hyperbus_cs_state_e;

  // 4 us of CS-low at a 166 MHz PHY clock
  localparam int unsigned T_CSM_DEFAULT_CYCLES  = 664;
  localparam int unsigned T_CSHI_DEFAULT_CYCLES = 2;

endpackage
`default_nettype wire

// File: rtl/hyperbus_sat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hyperbus_sat_counter: clear / load-to-1 / increment counter, optionally saturating.
// Rev 1.0
// ----------------------------------------------------------------------------
module hyperbus_sat_counter #(
  parameter int WIDTH    = 12,
  parameter bit SATURATE = 1'b1
) (
  input  logic             tx_clk_90,
  input  logic             rst_ni,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = SATURATE && (&r_count);

  always_ff @(posedge tx_clk_90 or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= C_ONE;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + C_ONE;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/hyperbus_cs_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hyperbus_cs_timer: t_CSM / t_CSHI guard on the registered HyperBus CS vector.
// Optional statistics with HYPERBUS_CS_TIMER_STATS_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module hyperbus_cs_timer
  import hyperbus_pkg::*;
#(
  parameter int NumChips = 2,
  parameter int CntWidth = 12
) (
  input  logic                tx_clk_90,
  input  logic                rst_ni,
  input  logic [NumChips-1:0] hyper_cs_ni,
  input  logic [CntWidth-1:0] cfg_max_low_i,
  input  logic [CntWidth-1:0] cfg_split_margin_i,
  input  logic [CntWidth-1:0] cfg_min_high_i,
  input  logic                err_clear_i,
  output logic                ready_o,
  output logic                split_req_o,
  output logic                err_tcsm_o,
  output logic                err_tcshi_o,
  output logic                err_multi_cs_o,
  output logic [15:0]         stat_trx_cnt_o,
  output logic [CntWidth-1:0] stat_max_low_o
);

  localparam logic [1:0] S_READY   = READY;
  localparam logic [1:0] S_ACTIVE  = ACTIVE;
  localparam logic [1:0] S_RECOVER = RECOVER;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [CntWidth-1:0] r_cnt;
  logic                w_cnt_load;
  logic                w_cnt_inc;
  logic                w_cs_low;
  logic                w_multi_cs;
  logic [CntWidth-1:0] w_split_thr;
  logic                w_set_tcsm;
  logic                w_set_tcshi;
  logic                r_err_tcsm;
  logic                r_err_tcshi;
  logic                r_err_multi_cs;

  assign w_cs_low   = ~&hyper_cs_ni;
  assign w_multi_cs = $countones(~hyper_cs_ni) > 1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_READY: begin
        if (w_cs_low) begin
          w_state_nxt = S_ACTIVE;
          w_cnt_load  = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (!w_cs_low) begin
          w_state_nxt = S_RECOVER;
          w_cnt_load  = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_RECOVER: begin
        // A reassertion wins over a recovery that would complete this cycle
        if (w_cs_low) begin
          w_state_nxt = S_ACTIVE;
          w_cnt_load  = 1'b1;
        end else if (r_cnt >= cfg_min_high_i) begin
          w_state_nxt = S_READY;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_state_nxt = S_READY;
    endcase
  end

  hyperbus_sat_counter #(
    .WIDTH    (CntWidth),
    .SATURATE (1'b1)
  ) u_cnt (
    .tx_clk_90 (tx_clk_90),
    .rst_ni    (rst_ni),
    .i_clr     (1'b0),
    .i_load    (w_cnt_load),
    .i_inc     (w_cnt_inc),
    .o_count   (r_cnt)
  );

  assign w_split_thr = (cfg_max_low_i > cfg_split_margin_i) ?
                       (cfg_max_low_i - cfg_split_margin_i) : '0;
  assign w_set_tcsm  = (r_state == S_ACTIVE) && (r_cnt > cfg_max_low_i);
  assign w_set_tcshi = (r_state == S_RECOVER) && w_cs_low;

  always_ff @(posedge tx_clk_90 or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= S_READY;
      r_err_tcsm     <= 1'b0;
      r_err_tcshi    <= 1'b0;
      r_err_multi_cs <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_err_tcsm     <= w_set_tcsm  | (r_err_tcsm     & ~err_clear_i);
      r_err_tcshi    <= w_set_tcshi | (r_err_tcshi    & ~err_clear_i);
      r_err_multi_cs <= w_multi_cs  | (r_err_multi_cs & ~err_clear_i);
    end
  end

  assign ready_o        = (r_state == S_READY);
  assign split_req_o    = (r_state == S_ACTIVE) && (r_cnt >= w_split_thr);
  // The over-limit condition is visible in the cycle it first holds
  assign err_tcsm_o     = r_err_tcsm | w_set_tcsm;
  assign err_tcshi_o    = r_err_tcshi;
  assign err_multi_cs_o = r_err_multi_cs;

`ifdef HYPERBUS_CS_TIMER_STATS_EN
  logic                w_enter_active;
  logic [CntWidth-1:0] r_max_low;

  assign w_enter_active = (r_state != S_ACTIVE) && (w_state_nxt == S_ACTIVE);

  hyperbus_sat_counter #(
    .WIDTH    (16),
    .SATURATE (1'b0)
  ) u_trx_cnt (
    .tx_clk_90 (tx_clk_90),
    .rst_ni    (rst_ni),
    .i_clr     (err_clear_i),
    .i_load    (1'b0),
    .i_inc     (w_enter_active),
    .o_count   (stat_trx_cnt_o)
  );

  always_ff @(posedge tx_clk_90 or negedge rst_ni) begin
    if (!rst_ni) begin
      r_max_low <= '0;
    end else if (err_clear_i) begin
      r_max_low <= '0;
    end else if ((r_state == S_ACTIVE) && !w_cs_low && (r_cnt > r_max_low)) begin
      r_max_low <= r_cnt;
    end
  end

  assign stat_max_low_o = r_max_low;
`else
  assign stat_trx_cnt_o = '0;
  assign stat_max_low_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_cs_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hyperbus_cs_timer: directed and randomized CS patterns against a burst-level model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_hyperbus_cs_timer;

  localparam int CW  = 12;
  localparam int SAT = (1 << CW) - 1;

  logic          tx_clk_90 = 1'b0;
  logic          rst_ni;
  logic [1:0]    hyper_cs_ni;
  logic [CW-1:0] cfg_max_low_i;
  logic [CW-1:0] cfg_split_margin_i;
  logic [CW-1:0] cfg_min_high_i;
  logic          err_clear_i;
  logic          ready_o;
  logic          split_req_o;
  logic          err_tcsm_o;
  logic          err_tcshi_o;
  logic          err_multi_cs_o;
  logic [15:0]   stat_trx_cnt_o;
  logic [CW-1:0] stat_max_low_o;

  int checks   = 0;
  int failures = 0;

  hyperbus_cs_timer #(
    .NumChips (2),
    .CntWidth (CW)
  ) dut (
    .tx_clk_90          (tx_clk_90),
    .rst_ni             (rst_ni),
    .hyper_cs_ni        (hyper_cs_ni),
    .cfg_max_low_i      (cfg_max_low_i),
    .cfg_split_margin_i (cfg_split_margin_i),
    .cfg_min_high_i     (cfg_min_high_i),
    .err_clear_i        (err_clear_i),
    .ready_o            (ready_o),
    .split_req_o        (split_req_o),
    .err_tcsm_o         (err_tcsm_o),
    .err_tcshi_o        (err_tcshi_o),
    .err_multi_cs_o     (err_multi_cs_o),
    .stat_trx_cnt_o     (stat_trx_cnt_o),
    .stat_max_low_o     (stat_max_low_o)
  );

  always #5 tx_clk_90 = ~tx_clk_90;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Burst-level model: a burst is a run of low samples, recovery counts high samples
  bit          m_burst  = 1'b0;
  bit          m_guard  = 1'b0;
  int          m_low    = 0;
  int          m_high   = 0;
  bit          m_tcsm   = 1'b0;
  bit          m_tcshi  = 1'b0;
  bit          m_multi  = 1'b0;
  logic [15:0] m_trx    = '0;
  int          m_maxlow = 0;
  bit          mt_low, mt_multi, mt_set_tcsm, mt_set_tcshi;

  always @(posedge tx_clk_90 or negedge rst_ni) begin
    if (!rst_ni) begin
      m_burst = 0; m_guard = 0; m_low = 0; m_high = 0;
      m_tcsm = 0; m_tcshi = 0; m_multi = 0; m_trx = '0; m_maxlow = 0;
    end else begin
      mt_low       = (hyper_cs_ni != 2'b11);
      mt_multi     = $countones(~hyper_cs_ni) > 1;
      mt_set_tcsm  = m_burst && (sat(m_low) > int'(cfg_max_low_i));
      mt_set_tcshi = m_guard && mt_low;
      m_tcsm  = mt_set_tcsm  || (m_tcsm  && !err_clear_i);
      m_tcshi = mt_set_tcshi || (m_tcshi && !err_clear_i);
      m_multi = mt_multi     || (m_multi && !err_clear_i);
      if (m_burst) begin
        if (mt_low) begin
          m_low++;
        end else begin
          if (sat(m_low) > m_maxlow) m_maxlow = sat(m_low);
          m_burst = 0; m_guard = 1; m_high = 1;
        end
      end else if (m_guard && !mt_low) begin
        if (m_high >= int'(cfg_min_high_i)) m_guard = 0;
        else m_high++;
      end else if (mt_low) begin
        m_trx++;
        m_burst = 1; m_guard = 0; m_low = 1;
      end
      if (err_clear_i) begin
        m_trx = '0; m_maxlow = 0;
      end
    end
  end

  int e_thr;
  always @(negedge tx_clk_90) begin
    e_thr = (cfg_max_low_i > cfg_split_margin_i) ?
            (int'(cfg_max_low_i) - int'(cfg_split_margin_i)) : 0;
    check("ready",    ready_o,        !m_burst && !m_guard);
    check("split",    split_req_o,    m_burst && (sat(m_low) >= e_thr));
    check("tcsm",     err_tcsm_o,     m_tcsm || (m_burst && (sat(m_low) > int'(cfg_max_low_i))));
    check("tcshi",    err_tcshi_o,    m_tcshi);
    check("multi_cs", err_multi_cs_o, m_multi);
`ifdef HYPERBUS_CS_TIMER_STATS_EN
    check("stat_trx", stat_trx_cnt_o, m_trx);
    check("stat_max", stat_max_low_o, m_maxlow);
`else
    check("stat_trx", stat_trx_cnt_o, 0);
    check("stat_max", stat_max_low_o, 0);
`endif
  end

  // Called at negedge+2; returns one cycle later after the DUT sampled cs/clr
  task automatic cyc(input logic [1:0] cs, input logic clr);
    hyper_cs_ni = cs;
    err_clear_i = clr;
    @(negedge tx_clk_90);
    #2;
  endtask

  int lo, hi;
  logic [1:0] pat;

  initial begin
    rst_ni = 1'b0; hyper_cs_ni = 2'b11; err_clear_i = 1'b0;
    cfg_max_low_i = 12'd20; cfg_split_margin_i = 12'd4; cfg_min_high_i = 12'd3;
    repeat (3) @(negedge tx_clk_90);
    #2;
    check("rst_ready", ready_o, 1);
    check("rst_split", split_req_o, 0);
    check("rst_tcsm",  err_tcsm_o, 0);
    check("rst_multi", err_multi_cs_o, 0);
    check("rst_trx",   stat_trx_cnt_o, 0);
    rst_ni = 1'b1;
    cyc(2'b11, 1'b0);

    for (int i = 1; i <= 25; i++) begin
      cyc(2'b10, 1'b0);
      if (i == 15) check("split_low15", split_req_o, 0);
      if (i == 16) check("split_low16", split_req_o, 1);
      if (i == 20) check("tcsm_low20", err_tcsm_o, 0);
      if (i == 21) check("tcsm_low21", err_tcsm_o, 1);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc(2'b11, 1'b0);
      check("recover_ready", ready_o, i == 4);
      if (i == 1) begin
        check("split_off", split_req_o, 0);
        check("tcsm_sticky", err_tcsm_o, 1);
      end
    end
    cyc(2'b11, 1'b1);
    check("tcsm_cleared", err_tcsm_o, 0);

    cyc(2'b10, 1'b0); cyc(2'b10, 1'b0);
    cyc(2'b11, 1'b0); cyc(2'b11, 1'b0);
    cyc(2'b10, 1'b0);
    check("tcshi_set", err_tcshi_o, 1);
    check("tcshi_not_ready", ready_o, 0);
    cyc(2'b10, 1'b0);
    check("tcshi_active", split_req_o, 0);
    repeat (5) cyc(2'b11, 1'b0);

    cyc(2'b00, 1'b0);
    check("multi_set", err_multi_cs_o, 1);
    cyc(2'b11, 1'b1);
    check("multi_clear", err_multi_cs_o, 0);
    cyc(2'b00, 1'b1);
    check("multi_set_wins", err_multi_cs_o, 1);
    repeat (5) cyc(2'b11, 1'b0);
    cyc(2'b11, 1'b1);

    cfg_split_margin_i = 12'd30;
    cyc(2'b10, 1'b0);
    check("split_margin_sat", split_req_o, 1);
    repeat (5) cyc(2'b11, 1'b0);

    cfg_max_low_i = 12'd4095; cfg_split_margin_i = 12'd0;
    for (int i = 1; i <= 4100; i++) begin
      cyc(2'b01, 1'b0);
      if (i == 4094) check("split_4094", split_req_o, 0);
      if (i == 4095) check("split_4095", split_req_o, 1);
      if (i == 4100) check("split_held_sat", split_req_o, 1);
      if (i == 4100) check("tcsm_no_sat_err", err_tcsm_o, 0);
    end
    repeat (5) cyc(2'b11, 1'b0);
`ifdef HYPERBUS_CS_TIMER_STATS_EN
    check("stat_max_sat", stat_max_low_o, 4095);
`endif

    cfg_max_low_i = 12'd20; cfg_split_margin_i = 12'd4; cfg_min_high_i = 12'd3;
    repeat (22) cyc(2'b10, 1'b0);
    check("pre_reset_tcsm", err_tcsm_o, 1);
    rst_ni = 1'b0;
    #1;
    check("async_ready", ready_o, 1);
    check("async_split", split_req_o, 0);
    check("async_tcsm",  err_tcsm_o, 0);
    check("async_tcshi", err_tcshi_o, 0);
    check("async_multi", err_multi_cs_o, 0);
    check("async_trx",   stat_trx_cnt_o, 0);
    check("async_max",   stat_max_low_o, 0);
    @(negedge tx_clk_90);
    #2;
    rst_ni = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc(2'b10, 1'b0);
      if (i == 1) check("post_reset_active", ready_o, 0);
`ifdef HYPERBUS_CS_TIMER_STATS_EN
      if (i == 1) check("post_reset_trx", stat_trx_cnt_o, 1);
`endif
      if (i == 15) check("post_reset_split15", split_req_o, 0);
      if (i == 16) check("post_reset_split16", split_req_o, 1);
    end
    repeat (5) cyc(2'b11, 1'b0);

    for (int b = 0; b < 160; b++) begin
      if ($urandom_range(2, 0) == 0) begin
        cfg_max_low_i      = 12'($urandom_range(40, 3));
        cfg_split_margin_i = 12'($urandom_range(45, 0));
        cfg_min_high_i     = 12'($urandom_range(6, 0));
      end
      lo = $urandom_range(30, 1);
      for (int k = 0; k < lo; k++) begin
        pat = ($urandom_range(29, 0) == 0) ? 2'b00 : (b[0] ? 2'b01 : 2'b10);
        cyc(pat, $urandom_range(24, 0) == 0);
      end
      hi = $urandom_range(8, 0);
      for (int k = 0; k < hi; k++) cyc(2'b11, $urandom_range(24, 0) == 0);
      if ($urandom_range(19, 0) == 0) begin
        rst_ni = 1'b0;
        @(negedge tx_clk_90);
        #2;
        rst_ni = 1'b1;
      end
    end
    repeat (10) cyc(2'b11, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
